dmem_bridge: RTL

Data-memory bus bridge between the single-cycle core's load/store signals (`mem_read`, `mem_write`, ALU address, register bus B data) and a multi-cycle ready/acknowledge memory bus. It holds the core with a `stall` output until the bus completes. It registers read data, detects misaligned accesses and bus timeouts, and reports errors through a sticky status flag. It replaces the direct core-to-`DataMemory` connection when memory has wait states.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/bus_timeout_ctr.sv | 38 +++
 rtl/dmem_bridge.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package dmem_pkg;

  localparam int CTR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } dmem_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_BUS     = 2'b11;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Bus wait-cycle counter: clears on demand, counts while enabled, and flags
// the last wait cycle allowed before the bridge gives up on the bus.
module bus_timeout_ctr
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CTR_W-1:0] LAST = CTR_W'(TIMEOUT_CYCLES - 1);

  logic [CTR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle load/store strobes onto a multi-cycle ack bus,
// stalling the core until completion and keeping a sticky first-error status.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              err,
  input  logic              err_clr,
  output logic [1:0]        err_code,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [DATA_W-1:0] bus_rdata
);

  dmem_state_t       state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              new_err;
  logic [1:0]        new_code;
  logic              tmo_tc;

  // bus_req is a pure state decode so an asserted reset drops it at once.
  assign bus_req = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign stall   = (mem_read || mem_write) && (state_q != DONE);

  bus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(!bus_req),
    .en (bus_req),
    .tc (tmo_tc)
  );

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    new_err     = 1'b0;
    new_code    = ERR_NONE;

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (addr[1:0] != 2'b00) begin
            new_err  = 1'b1;
            new_code = ERR_ALIGN;
            if (!mem_write) rdata_d = '0;
            state_d  = DONE;
          end else begin
            bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            bus_wdata_d = wdata;
            bus_we_d    = mem_write;
            state_d     = mem_write ? WR_WAIT : RD_WAIT;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        // An ack on the terminal cycle still counts as a completion.
        if (bus_ack) begin
          if (bus_err) begin
            new_err  = 1'b1;
            new_code = ERR_BUS;
            rdata_d  = '0;
          end else if (state_q == RD_WAIT) begin
            rdata_d = bus_rdata;
          end
          state_d = DONE;
        end else if (tmo_tc) begin
          new_err  = 1'b1;
          new_code = ERR_TIMEOUT;
          rdata_d  = '0;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (err_clr) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end
    // Only the first error since the last clear records its code.
    if (new_err) begin
      err_d = 1'b1;
      if (!err_q || err_clr) err_code_d = new_code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule
